// File: rtl/cpu_cu_pkg.sv
// Shared definitions for the cpu_cu control unit: state encoding, opcode and
// condition-code constants, and the ALU pass-through codes it drives.
package cpu_cu_pkg;

  // Control states; RESET must stay at 0 so the debug port reads 0 in reset.
  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC    = 4'd3,
    ST_LOAD    = 4'd4,
    ST_STORE   = 4'd5,
    ST_BRANCH  = 4'd6,
    ST_JUMP    = 4'd7,
    ST_HALT    = 4'd8,
    ST_ILLEGAL = 4'd9
  } state_e;

  // Opcodes in IR[15:12]; 0x0-0x7 are ALU operations.
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Branch condition codes in IR[11:8]; 7-15 never take the branch.
  localparam logic [3:0] CC_ALWAYS = 4'd0;
  localparam logic [3:0] CC_C      = 4'd1;
  localparam logic [3:0] CC_NC     = 4'd2;
  localparam logic [3:0] CC_Z      = 4'd3;
  localparam logic [3:0] CC_NZ     = 4'd4;
  localparam logic [3:0] CC_N      = 4'd5;
  localparam logic [3:0] CC_NN     = 4'd6;

  // ALU codes that route one operand straight to the ALU output.
  localparam logic [3:0] ALU_PASS_S = 4'hA;
  localparam logic [3:0] ALU_PASS_R = 4'h9;

  // True for the eight ALU opcodes (top opcode bit clear).
  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/cpu_cond_eval.sv
// Branch condition evaluator: decides whether a BR is taken from its
// condition code and the registered C/N/Z status.
module cpu_cond_eval
  import cpu_cu_pkg::*;
(
  input  logic [3:0] cc_i,
  input  logic       c_i,
  input  logic       n_i,
  input  logic       z_i,
  output logic       taken_o
);

  // Pure decode of the condition code; unassigned codes are never taken.
  always_comb begin
    taken_o = 1'b0;
    case (cc_i)
      CC_ALWAYS: taken_o = 1'b1;
      CC_C:      taken_o = c_i;
      CC_NC:     taken_o = ~c_i;
      CC_Z:      taken_o = z_i;
      CC_NZ:     taken_o = ~z_i;
      CC_N:      taken_o = n_i;
      CC_NN:     taken_o = ~n_i;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_cu.sv
// Multi-cycle control unit for cpu_eu: fetch/decode/execute sequencer with a
// registered C/N/Z status used by conditional branches.
//
// Memory handshake: mem_rd / mem_wr act as "valid" and are held steady, with
// address selection, for as long as the controller is in FETCH, LOAD or
// STORE. mem_rdy acts as "ready"; a transfer completes in the cycle where the
// request and mem_rdy are both high, and only then does the state advance.
// mem_rdy is ignored in every other state.
module cpu_cu
  import cpu_cu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_OUT,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_rdy,
  output logic [3:0]  Alu_Op,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic        adr_sel,
  output logic        s_sel,
  output logic        reg_w_en,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state_out
);

  state_e state_q, state_d;
  logic   c_q, n_q, z_q;
  logic   taken;

  logic [3:0] op, cc;
  logic [2:0] w_fld, r_fld, s_fld;

  assign op    = IR_OUT[15:12];
  assign cc    = IR_OUT[11:8];
  assign w_fld = IR_OUT[8:6];
  assign r_fld = IR_OUT[5:3];
  assign s_fld = IR_OUT[2:0];

  assign state_out = state_q;

  cpu_cond_eval u_cond (
    .cc_i    (cc),
    .c_i     (c_q),
    .n_i     (n_q),
    .z_i     (z_q),
    .taken_o (taken)
  );

  // State register; reset forces RESET immediately so all outputs drop to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Status register: captures live ALU flags only when an ALU op executes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      c_q <= C;
      n_q <= N;
      z_q <= Z;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  if (mem_rdy) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_alu_op(op)) begin
          state_d = ST_EXEC;
        end else begin
          case (op)
            OP_LD:   state_d = ST_LOAD;
            OP_ST:   state_d = ST_STORE;
            OP_BR:   state_d = ST_BRANCH;
            OP_JMP:  state_d = ST_JUMP;
            OP_HALT: state_d = ST_HALT;
            default: state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_EXEC, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_LOAD, ST_STORE: if (mem_rdy) state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_RESET;
    endcase
  end

  // Output decode from the current state and instruction fields.
  always_comb begin
    Alu_Op   = 4'h0;
    W_Adr    = 3'd0;
    R_Adr    = 3'd0;
    S_Adr    = 3'd0;
    adr_sel  = 1'b0;
    s_sel    = 1'b0;
    reg_w_en = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_sel   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
      end
      ST_EXEC: begin
        reg_w_en = 1'b1;
        Alu_Op   = op;
        W_Adr    = w_fld;
        R_Adr    = r_fld;
        S_Adr    = s_fld;
      end
      ST_LOAD: begin
        adr_sel = 1'b1;
        R_Adr   = r_fld;
        mem_rd  = 1'b1;
        if (mem_rdy) begin
          s_sel    = 1'b1;
          Alu_Op   = ALU_PASS_S;
          W_Adr    = w_fld;
          reg_w_en = 1'b1;
        end
      end
      ST_STORE: begin
        adr_sel = 1'b1;
        R_Adr   = r_fld;
        S_Adr   = s_fld;
        Alu_Op  = ALU_PASS_S;
        mem_wr  = 1'b1;
      end
      ST_BRANCH: pc_ld = taken;
      ST_JUMP: begin
        R_Adr  = r_fld;
        Alu_Op = ALU_PASS_R;
        pc_sel = 1'b1;
        pc_ld  = 1'b1;
      end
      ST_HALT:    halted  = 1'b1;
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_cu.sv
// Testbench for cpu_cu: instruction table with a scoreboard of expected
// output bundles, plus hand-written wait-state, reset and terminal sequences.
module tb_cpu_cu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IR_OUT;
  logic        C, N, Z, mem_rdy;
  logic [3:0]  Alu_Op;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic        adr_sel, s_sel, reg_w_en, ir_ld, pc_ld, pc_inc, pc_sel;
  logic        mem_rd, mem_wr, halted, illegal;
  logic [3:0]  state_out;

  int checks   = 0;
  int failures = 0;

  // Expected state encodings
  localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_EXEC = 4'd3, S_LOAD = 4'd4, S_STORE = 4'd5,
                         S_BRANCH = 4'd6, S_JUMP = 4'd7, S_HALT = 4'd8,
                         S_ILLEGAL = 4'd9;

  // Strobe bit positions within the packed output bundle
  localparam logic [10:0] B_ADR = 11'h400, B_SSEL = 11'h200, B_WEN = 11'h100,
                          B_IRLD = 11'h080, B_PCLD = 11'h040, B_PCINC = 11'h020,
                          B_PCSEL = 11'h010, B_RD = 11'h008, B_WR = 11'h004,
                          B_HALT = 11'h002, B_ILL = 11'h001;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        c, n, z;
    logic [27:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [27:0] exp_q[$];

  cpu_cu dut (
    .clk(clk), .reset(reset), .IR_OUT(IR_OUT), .C(C), .N(N), .Z(Z),
    .mem_rdy(mem_rdy), .Alu_Op(Alu_Op), .W_Adr(W_Adr), .R_Adr(R_Adr),
    .S_Adr(S_Adr), .adr_sel(adr_sel), .s_sel(s_sel), .reg_w_en(reg_w_en),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal),
    .state_out(state_out)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input logic [3:0] alu, input logic [2:0] w,
                                     input logic [2:0] r, input logic [2:0] s,
                                     input logic [10:0] strb, input logic [3:0] st);
    return {alu, w, r, s, strb, st};
  endfunction

  function automatic logic [27:0] act_vec();
    return {Alu_Op, W_Adr, R_Adr, S_Adr, adr_sel, s_sel, reg_w_en, ir_ld,
            pc_ld, pc_inc, pc_sel, mem_rd, mem_wr, halted, illegal, state_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the oldest expected bundle and compares it with the DUT now.
  task automatic chk_next(input string nm);
    logic [27:0] exp, act;
    act = act_vec();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty act=%h", nm, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
    end
  endtask

  task automatic expect_now(input string nm, input logic [27:0] exp);
    exp_q.push_back(exp);
    chk_next(nm);
  endtask

  // Called at posedge+1 with the DUT in FETCH; ends at posedge+1 one cycle
  // after the execute-phase state.
  task automatic run_instr(input string nm, input logic [15:0] ir,
                           input logic c, input logic n, input logic z,
                           input logic [27:0] exp);
    IR_OUT = ir; C = c; N = n; Z = z; mem_rdy = 1'b1;
    exp_q.push_back(mk(4'h0, 3'd0, 3'd0, 3'd0, B_IRLD | B_PCINC | B_RD, S_FETCH));
    exp_q.push_back(mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_DECODE));
    exp_q.push_back(exp);
    #1 chk_next({nm, "_fetch"});
    tick();
    chk_next({nm, "_decode"});
    tick();
    chk_next(nm);
    tick();
  endtask

  // Asynchronous reset pulse; returns at posedge+1 in FETCH.
  task automatic do_reset(input string nm);
    reset = 1'b0;
    #1 expect_now({nm, "_zero"}, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_RESET));
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Invariants checked every cycle out of reset
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((pc_ld && pc_inc) || (mem_rd && mem_wr) ||
          (reg_w_en && state_out != S_EXEC && !(state_out == S_LOAD && mem_rdy))) begin
        failures++;
        $display("FAIL invariant pc_ld=%b pc_inc=%b rd=%b wr=%b wen=%b state=%0d",
                 pc_ld, pc_inc, mem_rd, mem_wr, reg_w_en, state_out);
      end
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish act=timeout exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; IR_OUT = 16'h0000; C = 1'b0; N = 1'b0; Z = 1'b0; mem_rdy = 1'b0;

    tbl.push_back('{"add",      16'h0A53, 1'b0, 1'b0, 1'b0, mk(4'h0, 3'd1, 3'd2, 3'd3, B_WEN, S_EXEC)});
    tbl.push_back('{"sub_z",    16'h1A53, 1'b0, 1'b0, 1'b1, mk(4'h1, 3'd1, 3'd2, 3'd3, B_WEN, S_EXEC)});
    tbl.push_back('{"br_z_t",   16'hC3FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"ld",       16'h8050, 1'b1, 1'b1, 1'b0, mk(4'hA, 3'd1, 3'd2, 3'd0, B_ADR | B_SSEL | B_WEN | B_RD, S_LOAD)});
    tbl.push_back('{"br_z_t2",  16'hC3FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"st",       16'h9053, 1'b1, 1'b1, 1'b0, mk(4'hA, 3'd0, 3'd2, 3'd3, B_ADR | B_WR, S_STORE)});
    tbl.push_back('{"br_z_t3",  16'hC3FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"op2_c",    16'h2A53, 1'b1, 1'b0, 1'b0, mk(4'h2, 3'd1, 3'd2, 3'd3, B_WEN, S_EXEC)});
    tbl.push_back('{"br_z_nt",  16'hC3FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH)});
    tbl.push_back('{"br_c_t",   16'hC1FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"br_nc_nt", 16'hC2FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH)});
    tbl.push_back('{"br_nz_t",  16'hC4FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"op7_n",    16'h7A53, 1'b0, 1'b1, 1'b0, mk(4'h7, 3'd1, 3'd2, 3'd3, B_WEN, S_EXEC)});
    tbl.push_back('{"br_n_t",   16'hC5FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"br_nn_nt", 16'hC6FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH)});
    tbl.push_back('{"br_c_nt",  16'hC1FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH)});
    tbl.push_back('{"br_cc7",   16'hC7FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH)});
    tbl.push_back('{"br_ccf",   16'hCFFE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH)});
    tbl.push_back('{"br_al",    16'hC0FE, 1'b0, 1'b0, 1'b0, mk(4'h0, 3'd0, 3'd0, 3'd0, B_PCLD, S_BRANCH)});
    tbl.push_back('{"jmp",      16'hD038, 1'b0, 1'b0, 1'b0, mk(4'h9, 3'd0, 3'd7, 3'd0, B_PCLD | B_PCSEL, S_JUMP)});

    // Reset state, then release into a FETCH that waits on memory
    #3 expect_now("reset_state", mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_RESET));
    @(negedge clk);
    reset = 1'b1;
    tick();
    expect_now("fetch_wait1", mk(4'h0, 3'd0, 3'd0, 3'd0, B_RD, S_FETCH));
    tick();
    expect_now("fetch_wait2", mk(4'h0, 3'd0, 3'd0, 3'd0, B_RD, S_FETCH));

    // Reset mid-FETCH with mem_rdy low
    #2 do_reset("rst_mid_fetch");
    expect_now("fetch_after_rst", mk(4'h0, 3'd0, 3'd0, 3'd0, B_RD, S_FETCH));

    // Instruction table
    foreach (tbl[i]) run_instr(tbl[i].name, tbl[i].ir, tbl[i].c, tbl[i].n, tbl[i].z, tbl[i].exp);

    // LD with two memory wait cycles
    IR_OUT = 16'h8050; mem_rdy = 1'b1;
    tick();
    tick();
    mem_rdy = 1'b0;
    exp_q.push_back(mk(4'h0, 3'd0, 3'd2, 3'd0, B_ADR | B_RD, S_LOAD));
    #1 chk_next("ld_wait1");
    tick();
    exp_q.push_back(mk(4'h0, 3'd0, 3'd2, 3'd0, B_ADR | B_RD, S_LOAD));
    chk_next("ld_wait2");
    tick();
    mem_rdy = 1'b1;
    exp_q.push_back(mk(4'hA, 3'd1, 3'd2, 3'd0, B_ADR | B_SSEL | B_WEN | B_RD, S_LOAD));
    #1 chk_next("ld_done");
    tick();
    expect_now("ld_back_fetch", mk(4'h0, 3'd0, 3'd0, 3'd0, B_IRLD | B_PCINC | B_RD, S_FETCH));

    // Reset mid-STORE clears the status register
    run_instr("sub_z2", 16'h1A53, 1'b0, 1'b0, 1'b1, mk(4'h1, 3'd1, 3'd2, 3'd3, B_WEN, S_EXEC));
    IR_OUT = 16'h9053;
    tick();
    tick();
    mem_rdy = 1'b0;
    #1 expect_now("st_wait", mk(4'hA, 3'd0, 3'd2, 3'd3, B_ADR | B_WR, S_STORE));
    #2 do_reset("rst_mid_store");
    run_instr("br_after_rst", 16'hC3FE, 1'b1, 1'b1, 1'b1, mk(4'h0, 3'd0, 3'd0, 3'd0, 11'h000, S_BRANCH));

    // HALT is terminal and silent
    run_instr("halt", 16'hF000, 1'b0, 1'b0, 1'b0, mk(4'h0, 3'd0, 3'd0, 3'd0, B_HALT, S_HALT));
    for (int k = 0; k < 10; k++) begin
      mem_rdy = 1'($urandom_range(0, 1));
      IR_OUT  = 16'($urandom_range(0, 65535));
      #1 expect_now("halt_hold", mk(4'h0, 3'd0, 3'd0, 3'd0, B_HALT, S_HALT));
      tick();
    end

    // ILLEGAL is terminal and silent
    do_reset("rst_before_ill");
    run_instr("ill_a", 16'hA000, 1'b0, 1'b0, 1'b0, mk(4'h0, 3'd0, 3'd0, 3'd0, B_ILL, S_ILLEGAL));
    for (int k = 0; k < 10; k++) begin
      mem_rdy = 1'($urandom_range(0, 1));
      IR_OUT  = 16'($urandom_range(0, 65535));
      #1 expect_now("ill_hold", mk(4'h0, 3'd0, 3'd0, 3'd0, B_ILL, S_ILLEGAL));
      tick();
    end
    do_reset("rst_ill_b");
    run_instr("ill_b", 16'hB123, 1'b0, 1'b0, 1'b0, mk(4'h0, 3'd0, 3'd0, 3'd0, B_ILL, S_ILLEGAL));
    do_reset("rst_ill_e");
    run_instr("ill_e", 16'hE1FF, 1'b0, 1'b0, 1'b0, mk(4'h0, 3'd0, 3'd0, 3'd0, B_ILL, S_ILLEGAL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
